irda_fir_4ppm_decoder: RTL and testbench

//  FIR (4 Mb/s) 4PPM receive-side symbol decoder, the receive-direction counterpart of the FIR transmitter's 4PPM encoder.

---
 rtl/irda_fir_4ppm_decoder.sv | 239 +++++++++++++++++++++++
 tb/tb_irda_fir_4ppm_decoder.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irda_fir_4ppm_decoder.sv
// FIR (4 Mb/s) 4PPM receive decoder: preamble lock, start flag,
// data symbols to bytes, stop flag, frame length and symbol errors.
//
// Ports
//   clk          system clock
//   wb_rst_i     asynchronous reset, active low
//   chip_en      one-clk strobe per 125 ns chip; all chip logic advances on it
//   rx_i         synchronised chip level, 1 = optical pulse
//   restart_i    synchronous abort back to HUNT (wins over chip_en)
//   dat_o        decoded byte, qualified by dat_valid_o
//   dat_valid_o  one-clk pulse per decoded byte
//   sync_o       preamble lock held (PREAMBLE or DATA)
//   start_o      one-clk pulse, start flag accepted
//   stop_o       one-clk pulse, stop flag accepted, byte_cnt_o is final
//   sym_err_o    one-clk pulse, illegal data symbol
//   len_err_o    one-clk pulse, frame longer than MAX_LEN bytes
//   byte_cnt_o   bytes emitted in the current frame, cleared on start_o

module irda_fir_4ppm_decoder #(
    parameter int PRE_MATCH = 4,
    parameter int MAX_LEN   = 2050
) (
    input  logic        clk,
    input  logic        wb_rst_i,
    input  logic        chip_en,
    input  logic        rx_i,
    input  logic        restart_i,
    output logic [7:0]  dat_o,
    output logic        dat_valid_o,
    output logic        sync_o,
    output logic        start_o,
    output logic        stop_o,
    output logic        sym_err_o,
    output logic        len_err_o,
    output logic [11:0] byte_cnt_o
);

    // Flag patterns, oldest chip in the MSB.
    localparam logic [15:0] PRE   = 16'b1000_0000_1010_1000;
    localparam logic [31:0] START = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    localparam logic [31:0] STOP  = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

    localparam logic [3:0]  LOCK_CNT = 4'(PRE_MATCH);
    localparam logic [11:0] LEN_CAP  = 12'(MAX_LEN);

    typedef enum logic [1:0] {
        HUNT,
        PREAMBLE,
        DATA
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] sr, sr_nxt;
    logic [3:0]  phase, phase_nxt;
    logic [3:0]  match_cnt, match_nxt;
    logic [3:0]  skip_cnt, skip_nxt;
    logic [1:0]  dbp_idx, idx_nxt;
    logic [5:0]  acc, acc_nxt;
    logic [11:0] cnt_nxt;
    logic [7:0]  dat_nxt;
    logic        valid_nxt;
    logic        start_nxt;
    logic        stop_nxt;
    logic        sym_nxt;
    logic        len_nxt;

    // Window as it stands once the current chip is shifted in; every
    // check is made on it so pulses appear the clk after chip_en.
    logic [31:0] sr_sh;
    logic        pre_hit;
    logic [1:0]  dbp;
    logic        sym_ok;
    logic [7:0]  full_byte;

    assign sr_sh     = {sr[30:0], rx_i};
    assign pre_hit   = (sr_sh[15:0] == PRE);
    assign full_byte = {dbp, acc};

    always_comb begin
        dbp    = 2'd0;
        sym_ok = 1'b1;
        unique case (sr_sh[31:28])
            4'b1000: dbp = 2'd0;
            4'b0100: dbp = 2'd1;
            4'b0010: dbp = 2'd2;
            4'b0001: dbp = 2'd3;
            default: sym_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        sr_nxt    = sr;
        phase_nxt = phase;
        match_nxt = match_cnt;
        skip_nxt  = skip_cnt;
        idx_nxt   = dbp_idx;
        acc_nxt   = acc;
        cnt_nxt   = byte_cnt_o;
        dat_nxt   = dat_o;
        valid_nxt = 1'b0;
        start_nxt = 1'b0;
        stop_nxt  = 1'b0;
        sym_nxt   = 1'b0;
        len_nxt   = 1'b0;

        if (restart_i) begin
            state_nxt = HUNT;
            sr_nxt    = '0;
            phase_nxt = '0;
            match_nxt = '0;
            skip_nxt  = '0;
            idx_nxt   = '0;
            acc_nxt   = '0;
            cnt_nxt   = '0;
        end else if (chip_en) begin
            sr_nxt    = sr_sh;
            phase_nxt = phase + 4'd1;
            unique case (state)
                HUNT: begin
                    if (match_cnt == 4'd0) begin
                        // Free-running search; a hit fixes block phase.
                        if (pre_hit) begin
                            match_nxt = 4'd1;
                            phase_nxt = 4'd0;
                        end
                    end else if (phase == 4'hF) begin
                        if (pre_hit) begin
                            match_nxt = match_cnt + 4'd1;
                            if (match_cnt + 4'd1 == LOCK_CNT) begin
                                state_nxt = PREAMBLE;
                            end
                        end else begin
                            match_nxt = 4'd0;
                        end
                    end
                end
                PREAMBLE: begin
                    if (phase == 4'hF) begin
                        if (sr_sh == START) begin
                            state_nxt = DATA;
                            start_nxt = 1'b1;
                            cnt_nxt   = 12'd0;
                            skip_nxt  = 4'd8;
                            idx_nxt   = 2'd0;
                            acc_nxt   = 6'd0;
                        end else if (!pre_hit &&
                                     sr_sh[15:0] != START[31:16]) begin
                            state_nxt = HUNT;
                            match_nxt = 4'd0;
                        end
                    end
                end
                DATA: begin
                    if (phase[1:0] == 2'b11) begin
                        if (sr_sh == STOP) begin
                            stop_nxt  = 1'b1;
                            state_nxt = HUNT;
                            match_nxt = 4'd0;
                        end else if (skip_cnt > 4'd1) begin
                            // skip_cnt counts start-flag symbols still in
                            // the window; the last one leaves on this shift
                            // when skip_cnt is 1, so decoding starts then.
                            skip_nxt = skip_cnt - 4'd1;
                        end else if (!sym_ok) begin
                            skip_nxt  = 4'd0;
                            sym_nxt   = 1'b1;
                            state_nxt = HUNT;
                            match_nxt = 4'd0;
                        end else begin
                            skip_nxt = 4'd0;
                            if (dbp_idx == 2'd3) begin
                                idx_nxt = 2'd0;
                                acc_nxt = 6'd0;
                                if (byte_cnt_o >= LEN_CAP) begin
                                    len_nxt   = 1'b1;
                                    state_nxt = HUNT;
                                    match_nxt = 4'd0;
                                end else begin
                                    dat_nxt   = full_byte;
                                    valid_nxt = 1'b1;
                                    cnt_nxt   = byte_cnt_o + 12'd1;
                                end
                            end else begin
                                idx_nxt = dbp_idx + 2'd1;
                                unique case (dbp_idx)
                                    2'd0:    acc_nxt[1:0] = dbp;
                                    2'd1:    acc_nxt[3:2] = dbp;
                                    default: acc_nxt[5:4] = dbp;
                                endcase
                            end
                        end
                    end
                end
                default: begin
                    state_nxt = HUNT;
                    match_nxt = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state       <= HUNT;
            sr          <= '0;
            phase       <= '0;
            match_cnt   <= '0;
            skip_cnt    <= '0;
            dbp_idx     <= '0;
            acc         <= '0;
            byte_cnt_o  <= '0;
            dat_o       <= '0;
            dat_valid_o <= 1'b0;
            sync_o      <= 1'b0;
            start_o     <= 1'b0;
            stop_o      <= 1'b0;
            sym_err_o   <= 1'b0;
            len_err_o   <= 1'b0;
        end else begin
            state       <= state_nxt;
            sr          <= sr_nxt;
            phase       <= phase_nxt;
            match_cnt   <= match_nxt;
            skip_cnt    <= skip_nxt;
            dbp_idx     <= idx_nxt;
            acc         <= acc_nxt;
            byte_cnt_o  <= cnt_nxt;
            dat_o       <= dat_nxt;
            dat_valid_o <= valid_nxt;
            sync_o      <= (state_nxt != HUNT);
            start_o     <= start_nxt;
            stop_o      <= stop_nxt;
            sym_err_o   <= sym_nxt;
            len_err_o   <= len_nxt;
        end
    end

endmodule

// File: tb/tb_irda_fir_4ppm_decoder.sv
// Directed bench for irda_fir_4ppm_decoder: frame table plus
// reset, lock, illegal-symbol and abort sequences.
module tb_irda_fir_4ppm_decoder;

    localparam logic [15:0] PRE   = 16'b1000_0000_1010_1000;
    localparam logic [31:0] START = 32'b0000_1100_0000_1100_0110_0000_0110_0000;
    localparam logic [31:0] STOP  = 32'b0000_1100_0000_1100_0000_0110_0000_0110;

    logic clk = 1'b0;
    logic rst_n, chip_en, rx_i, restart;

    logic [7:0]  dat, l_dat;
    logic        dat_v, sync, start, stop, sym, len;
    logic        l_dat_v, l_sync, l_start, l_stop, l_sym, l_len;
    logic [11:0] bcnt, l_bcnt;

    always #5 clk = ~clk;

    irda_fir_4ppm_decoder dut (
        .clk(clk), .wb_rst_i(rst_n), .chip_en(chip_en), .rx_i(rx_i),
        .restart_i(restart), .dat_o(dat), .dat_valid_o(dat_v),
        .sync_o(sync), .start_o(start), .stop_o(stop),
        .sym_err_o(sym), .len_err_o(len), .byte_cnt_o(bcnt)
    );

    irda_fir_4ppm_decoder #(.PRE_MATCH(4), .MAX_LEN(2)) dut_len (
        .clk(clk), .wb_rst_i(rst_n), .chip_en(chip_en), .rx_i(rx_i),
        .restart_i(restart), .dat_o(l_dat), .dat_valid_o(l_dat_v),
        .sync_o(l_sync), .start_o(l_start), .stop_o(l_stop),
        .sym_err_o(l_sym), .len_err_o(l_len), .byte_cnt_o(l_bcnt)
    );

    int checks = 0;
    int errors = 0;
    int gap = 0;
    int chip_total = 0;
    int frame_base = 0;
    logic cq[$];
    int byte_end[$];

    // Event monitor, sampled away from the active edge.
    int n_valid = 0, n_start = 0, n_stop = 0, n_sym = 0;
    int m_valid = 0, m_len = 0, m_stop = 0;
    int sym_at = 0;
    logic [7:0] byte_q[$];
    int valid_at[$];

    always @(negedge clk) begin
        if (dat_v) begin
            byte_q.push_back(dat);
            valid_at.push_back(chip_total);
            n_valid++;
        end
        if (start) n_start++;
        if (stop) n_stop++;
        if (sym) begin
            n_sym++;
            sym_at = chip_total;
        end
        if (l_dat_v) m_valid++;
        if (l_len) m_len++;
        if (l_stop) m_stop++;
    end

    int s_valid, s_start, s_stop, s_sym, s_q, s_mv, s_ml, s_ms;

    task automatic snap();
        s_valid = n_valid; s_start = n_start; s_stop = n_stop;
        s_sym = n_sym; s_q = byte_q.size();
        s_mv = m_valid; s_ml = m_len; s_ms = m_stop;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [8:0] got_byte(input int i);
        if (i < byte_q.size()) return {1'b0, byte_q[i]};
        return 9'h1ff;
    endfunction

    function automatic int got_at(input int i);
        if (i < valid_at.size()) return valid_at[i];
        return -1;
    endfunction

    task automatic push_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) cq.push_back(w[i]);
    endtask

    task automatic push_pre(input int n);
        for (int i = 0; i < n; i++) push_word({16'h0, PRE}, 16);
    endtask

    task automatic push_zeros(input int n);
        for (int i = 0; i < n; i++) cq.push_back(1'b0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        logic [3:0] s;
        for (int k = 0; k < 4; k++) begin
            s = 4'b1000 >> b[2*k +: 2];
            push_word({28'h0, s}, 4);
        end
        byte_end.push_back(cq.size());
    endtask

    task automatic push_frame(input int n, input logic [31:0] bytes);
        byte_end.delete();
        push_pre(16);
        push_word(START, 32);
        for (int i = 0; i < n; i++) push_byte(bytes[8*i +: 8]);
        push_word(STOP, 32);
        push_zeros(8);
    endtask

    task automatic chip(input logic b);
        chip_en = 1'b1;
        rx_i = b;
        @(posedge clk); #1;
        chip_en = 1'b0;
        chip_total++;
        for (int g = 0; g < gap; g++) begin
            rx_i = ~rx_i;
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input int restart_after, input int limit);
        frame_base = chip_total;
        for (int i = 0; i < cq.size(); i++) begin
            if (limit != 0 && i >= limit) break;
            chip(cq[i]);
            if (i + 1 == restart_after) begin
                restart = 1'b1;
                @(posedge clk); #1;
                restart = 1'b0;
                check("abort_sync", {31'h0, sync}, 32'h0);
            end
        end
        cq.delete();
    endtask

    typedef struct {
        int          n;
        logic [31:0] bytes;
        int          gap;
        int          l_valid;
        int          l_len;
        int          l_stop;
    } vec_t;

    vec_t vecs[4];
    int   sym_idx;

    initial begin
        vecs[0] = '{n:2, bytes:32'h0000_E41B, gap:0, l_valid:2, l_len:0, l_stop:1};
        vecs[1] = '{n:2, bytes:32'h0000_E41B, gap:4, l_valid:2, l_len:0, l_stop:1};
        vecs[2] = '{n:3, bytes:32'h000F_3CA5, gap:0, l_valid:2, l_len:1, l_stop:0};
        vecs[3] = '{n:2, bytes:32'h0000_FF00, gap:2, l_valid:2, l_len:0, l_stop:1};

        rst_n = 1'b0; chip_en = 1'b0; rx_i = 1'b0; restart = 1'b0;
        idle(3);
        check("reset_outs", {6'h0, dat, dat_v, sync, start, stop, sym, len, bcnt},
              32'h0);
        #2 rst_n = 1'b1;
        idle(3);

        // Frame table.
        foreach (vecs[v]) begin
            snap();
            gap = vecs[v].gap;
            push_frame(vecs[v].n, vecs[v].bytes);
            send(0, 0);
            gap = 0;
            idle(10);
            check($sformatf("v%0d_start", v), n_start - s_start, 1);
            check($sformatf("v%0d_stop", v), n_stop - s_stop, 1);
            check($sformatf("v%0d_nbytes", v), n_valid - s_valid, vecs[v].n);
            for (int i = 0; i < vecs[v].n; i++)
                check($sformatf("v%0d_byte%0d", v, i), got_byte(s_q + i),
                      {23'h0, 1'b0, vecs[v].bytes[8*i +: 8]});
            check($sformatf("v%0d_latency", v), got_at(s_q),
                  frame_base + byte_end[0] + 28);
            check($sformatf("v%0d_bcnt", v), bcnt, vecs[v].n);
            check($sformatf("v%0d_sync", v), {31'h0, sync}, 32'h0);
            check($sformatf("v%0d_len_bytes", v), m_valid - s_mv, vecs[v].l_valid);
            check($sformatf("v%0d_len_err", v), m_len - s_ml, vecs[v].l_len);
            check($sformatf("v%0d_len_stop", v), m_stop - s_ms, vecs[v].l_stop);
        end

        // Async reset in the middle of DATA.
        push_frame(2, 32'h0000_E41B);
        send(0, byte_end[0] + 30);
        check("mid_sync", {31'h0, sync}, 32'h1);
        check("mid_dat", {24'h0, dat}, 32'h1B);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_outs",
              {6'h0, dat, dat_v, sync, start, stop, sym, len, bcnt}, 32'h0);
        idle(3);
        snap();
        #3 rst_n = 1'b1;
        idle(40);
        check("post_reset_pulses",
              (n_valid - s_valid) + (n_start - s_start) +
              (n_stop - s_stop) + (n_sym - s_sym), 0);
        check("post_reset_sync", {31'h0, sync}, 32'h0);

        // Lock acquisition with a corrupt block in the middle.
        snap();
        push_zeros(20);
        cq.push_back(1'b1); cq.push_back(1'b1); cq.push_back(1'b0);
        cq.push_back(1'b1); cq.push_back(1'b1);
        push_pre(3);
        push_zeros(16);
        send(0, 0);
        check("lock_corrupt_sync", {31'h0, sync}, 32'h0);
        push_pre(3);
        send(0, 0);
        check("lock_3clean_sync", {31'h0, sync}, 32'h0);
        push_pre(1);
        send(0, 0);
        check("lock_4clean_sync", {31'h0, sync}, 32'h1);
        byte_end.delete();
        push_word(START, 32);
        push_byte(8'h1B);
        push_word(STOP, 32);
        push_zeros(8);
        send(0, 0);
        idle(4);
        check("lock_start", n_start - s_start, 1);
        check("lock_byte", got_byte(s_q), 32'h1B);
        check("lock_stop", n_stop - s_stop, 1);

        // Illegal symbol after one good byte.
        snap();
        byte_end.delete();
        push_pre(16);
        push_word(START, 32);
        push_byte(8'h55);
        push_word(32'hC, 4);
        sym_idx = cq.size();
        push_zeros(40);
        send(0, 0);
        idle(4);
        check("sym_err", n_sym - s_sym, 1);
        check("sym_at", sym_at, frame_base + sym_idx + 28);
        check("sym_nbytes", n_valid - s_valid, 1);
        check("sym_byte", got_byte(s_q), 32'h55);
        check("sym_sync", {31'h0, sync}, 32'h0);
        check("sym_stop", n_stop - s_stop, 0);

        // Abort during byte 3, then a clean frame.
        snap();
        push_frame(4, 32'h4433_2211);
        send(byte_end[1] + 36, 0);
        idle(4);
        check("abort_nbytes", n_valid - s_valid, 2);
        check("abort_byte0", got_byte(s_q), 32'h11);
        check("abort_byte1", got_byte(s_q + 1), 32'h22);
        check("abort_stop", n_stop - s_stop, 0);
        snap();
        push_frame(2, 32'h0000_E41B);
        send(0, 0);
        idle(4);
        check("after_abort_byte0", got_byte(s_q), 32'h1B);
        check("after_abort_byte1", got_byte(s_q + 1), 32'hE4);
        check("after_abort_stop", n_stop - s_stop, 1);
        check("after_abort_bcnt", bcnt, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
